cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Loads a program into instruction memory from a valid/ready
//            stream, then resets and runs an attached CPU until it writes its
//            completion value to data address 0.
// Options  : CYCLE_TIMEOUT_EN - when defined, a run is aborted with timeout=1
//            once the cycle counter reaches MAX_CYCLES-1 without completion.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6,
  parameter int MAX_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          start,
  output logic          cpu_reset,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result,
  output logic          timeout,
  output logic          overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RST   = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Reject parameter sets where the address bus cannot cover the memory.
  generate
    if (MAX_CYCLES < 2 || (1 << AW) < IMEM_DEPTH) begin : g_param_err
      $error("cpu_sequencer: inconsistent parameters");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic            r_rst_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_overflow;
  logic            r_done;
  logic [31:0]     r_result;

  logic            w_accept;
  logic            w_at_end;
  logic            w_complete;
  logic            w_expire;
  logic            w_load_entry;
  logic            w_run_entry;

  assign w_accept     = (r_state == S_LOAD) && ld_valid;
  assign w_at_end     = (r_addr == AW'(IMEM_DEPTH - 1));
  assign w_complete   = (r_state == S_RUN) && memwrite && (dataadr == 32'd0);
  assign w_load_entry = (w_next == S_LOAD) && (r_state != S_LOAD);
  // Second RST cycle: the CPU has seen reset for two full cycles.
  assign w_run_entry  = (r_state == S_RST) && r_rst_cnt;

  // Next-state decode; loader activity always outranks a run request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ld_valid) w_next = S_LOAD;
      S_LOAD:  if (w_accept && (ld_last || w_at_end)) w_next = S_READY;
      S_READY: if (start) w_next = S_RST;
      S_RST:   if (r_rst_cnt) w_next = S_RUN;
      S_RUN:   if (w_complete || w_expire) w_next = S_DONE;
      S_DONE: begin
        if (ld_valid)   w_next = S_LOAD;
        else if (start) w_next = S_RST;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and the two-cycle CPU reset counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rst_cnt <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rst_cnt <= (r_state == S_RST) && !r_rst_cnt;
    end
  end

  // Load address, overflow flag and run result; cleared when a new load or run begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      if (w_load_entry) begin
        r_addr     <= '0;
        r_overflow <= 1'b0;
        r_done     <= 1'b0;
        r_result   <= '0;
      end else if (w_accept) begin
        // The last memory word never wraps; without ld_last it flags overflow.
        if (w_at_end) begin
          if (!ld_last) r_overflow <= 1'b1;
        end else begin
          r_addr <= r_addr + AW'(1);
        end
      end
      if (w_run_entry) begin
        r_done   <= 1'b0;
        r_result <= '0;
      end else if (w_complete || w_expire) begin
        r_done <= 1'b1;
        if (w_complete) r_result <= writedata;
      end
    end
  end

`ifdef CYCLE_TIMEOUT_EN
  localparam int c_cw = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  logic [c_cw-1:0] r_cycles;
  logic            r_timeout;

  assign w_expire = (r_state == S_RUN) && (r_cycles == c_cw'(MAX_CYCLES - 1));

  // Run-cycle counter; a completion in the expiry cycle suppresses the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (w_run_entry) begin
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (w_load_entry) begin
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cycles <= r_cycles + c_cw'(1);
      if (w_expire && !w_complete) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign ld_ready   = (r_state == S_LOAD);
  assign imem_we    = w_accept;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_accept ? ld_data : 32'd0;
  assign cpu_reset  = (r_state != S_RUN);
  assign busy       = (r_state == S_LOAD) || (r_state == S_RST) || (r_state == S_RUN);
  assign done       = r_done;
  assign result     = r_result;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Directed self-checking bench for cpu_sequencer (loader, overflow,
//            run/complete, optional cycle timeout, mid-run reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int IMEM_DEPTH = 64;
  localparam int AW         = 6;
  localparam int MAX_CYCLES = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          start = 1'b0;
  logic          cpu_reset;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          memwrite = 1'b0;
  logic [31:0]   dataadr = '0;
  logic [31:0]   writedata = '0;
  logic          busy;
  logic          done;
  logic [31:0]   result;
  logic          timeout;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;

  cpu_sequencer #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .AW         (AW),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .start      (start),
    .cpu_reset  (cpu_reset),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .timeout    (timeout),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_ld_ready"},  32'(ld_ready),  32'd0);
    check({tag, "_imem_we"},   32'(imem_we),   32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_result"},    result,         32'd0);
    check({tag, "_timeout"},   32'(timeout),   32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  // Wait (bounded) until the CPU is released from reset.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (cpu_reset && n < 10) begin
      n++;
      tick();
    end
    check({tag, "_run_entry"}, 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic gap_valid [6];
    int   exp_addr;
    int   n;
    int   writes;

    gap_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Power-on reset values
    #12;
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // Three-word load; start held throughout is ignored
    ld_valid = 1'b1;
    start    = 1'b1;
    ld_data  = 32'h1000_0000;
    #1;
    check("idle_ld_ready", 32'(ld_ready), 32'd0);
    check("idle_imem_we",  32'(imem_we),  32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      ld_data = 32'h1000_0000 + 32'(i);
      ld_last = (i == 2);
      #1;
      check("ld3_we",    32'(imem_we),   32'd1);
      check("ld3_addr",  32'(imem_addr), 32'(i));
      check("ld3_wdata", imem_wdata,     32'h1000_0000 + 32'(i));
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    start    = 1'b0;
    #1;
    check("ld3_ready_state", 32'(ld_ready),  32'd0);
    check("ld3_busy",        32'(busy),      32'd0);
    check("ld3_overflow",    32'(overflow),  32'd0);
    check("ld3_cpu_reset",   32'(cpu_reset), 32'd1);

    // Reset clears the load address; then a load with valid gaps
    reset = 1'b0;
    #1;
    check("rst_addr", 32'(imem_addr), 32'd0);
    reset = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_data  = 32'h2000_0000;
    tick();
    exp_addr = 0;
    for (int k = 0; k < 6; k++) begin
      ld_valid = gap_valid[k];
      ld_data  = 32'h2000_0000 + 32'(k);
      ld_last  = (k == 5);
      #1;
      check("gap_we",   32'(imem_we),   32'(gap_valid[k]));
      check("gap_addr", 32'(imem_addr), 32'(exp_addr));
      if (gap_valid[k]) exp_addr++;
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    check("gap_done_ready", 32'(ld_ready), 32'd0);
    check("gap_busy",       32'(busy),     32'd0);

    // Run to completion with result 0x78
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cpu_reset && n < 10) begin
      n++;
      tick();
    end
    check("rst_len",    32'(n),    32'd2);
    check("run_busy",   32'(busy), 32'd1);
    check("run_done0",  32'(done), 32'd0);
    writedata = 32'h0000_dead;
    tick();
    memwrite  = 1'b1;
    dataadr   = 32'd4;
    writedata = 32'h0000_beef;
    tick();
    check("run_wrong_addr", 32'(done), 32'd0);
    dataadr   = 32'd0;
    writedata = 32'h0000_0078;
    tick();
    memwrite = 1'b0;
    #1;
    check("cmp_done",      32'(done),      32'd1);
    check("cmp_result",    result,         32'h0000_0078);
    check("cmp_timeout",   32'(timeout),   32'd0);
    check("cmp_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cmp_busy",      32'(busy),      32'd0);
    tick();
    tick();
    check("cmp_hold", result, 32'h0000_0078);

    // Rerun without reload; the CPU never completes
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("rerun");
    check("rerun_done_clr",   32'(done), 32'd0);
    check("rerun_result_clr", result,    32'd0);
`ifdef CYCLE_TIMEOUT_EN
    n = 0;
    while (!done && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles",  32'(n),       32'd16);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_result",  result,       32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("to_rerun");
    check("to_rerun_done",    32'(done),    32'd0);
    check("to_rerun_timeout", 32'(timeout), 32'd0);
    repeat (15) tick();
`else
    repeat (40) tick();
    check("noto_done",      32'(done),      32'd0);
    check("noto_timeout",   32'(timeout),   32'd0);
    check("noto_cpu_reset", 32'(cpu_reset), 32'd0);
`endif
    memwrite  = 1'b1;
    dataadr   = 32'd0;
    writedata = 32'h0000_0099;
    tick();
    memwrite = 1'b0;
    #1;
    check("late_done",    32'(done),    32'd1);
    check("late_timeout", 32'(timeout), 32'd0);
    check("late_result",  result,       32'h0000_0099);

    // Reload from DONE with start also asserted; overflow on 64 words
    ld_valid = 1'b1;
    start    = 1'b1;
    ld_data  = 32'h3000_0000;
    tick();
    check("reload_ld_ready", 32'(ld_ready), 32'd1);
    check("reload_done",     32'(done),     32'd0);
    check("reload_result",   result,        32'd0);
    writes = 0;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      ld_data = 32'h3000_0000 + 32'(i);
      #1;
      if (imem_we && (32'(imem_addr) == 32'(i)) && (imem_wdata == ld_data)) writes++;
      tick();
    end
    start = 1'b0;
    #1;
    check("ovf_writes",   32'(writes),   32'd64);
    check("ovf_flag",     32'(overflow), 32'd1);
    check("ovf_no_65th",  32'(imem_we),  32'd0);
    check("ovf_ld_ready", 32'(ld_ready), 32'd0);
    check("ovf_busy",     32'(busy),     32'd0);
    ld_valid = 1'b0;

    // Reset pulsed during a run
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("mid");
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midrun");
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("post_idle_cpu_reset", 32'(cpu_reset), 32'd1);
    check("post_idle_busy",      32'(busy),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
